// File: rtl/darksoc_pkg.sv
// Shared types and bus constants for the darksocv shared data/IO bus arbiter.
package darksoc_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/darkbus_arbiter_if.sv
// Bundle of the two master ports and the single slave port around the arbiter.
interface darkbus_arbiter_if;
  import darksoc_pkg::*;

  logic              M0_REQ;
  logic              M0_WR;
  logic [BE_W-1:0]   M0_BE;
  logic [ADDR_W-1:0] M0_ADDR;
  logic [DATA_W-1:0] M0_WDATA;
  logic              M0_ACK;
  logic [DATA_W-1:0] M0_RDATA;
  logic              M0_ERR;

  logic              M1_REQ;
  logic              M1_WR;
  logic [BE_W-1:0]   M1_BE;
  logic [ADDR_W-1:0] M1_ADDR;
  logic [DATA_W-1:0] M1_WDATA;
  logic              M1_ACK;
  logic [DATA_W-1:0] M1_RDATA;
  logic              M1_ERR;

  logic              S_REQ;
  logic              S_WR;
  logic [BE_W-1:0]   S_BE;
  logic [ADDR_W-1:0] S_ADDR;
  logic [DATA_W-1:0] S_WDATA;
  logic              S_ACK;
  logic [DATA_W-1:0] S_RDATA;

  modport arb (
    input  M0_REQ, M0_WR, M0_BE, M0_ADDR, M0_WDATA,
    input  M1_REQ, M1_WR, M1_BE, M1_ADDR, M1_WDATA,
    input  S_ACK, S_RDATA,
    output M0_ACK, M0_RDATA, M0_ERR,
    output M1_ACK, M1_RDATA, M1_ERR,
    output S_REQ, S_WR, S_BE, S_ADDR, S_WDATA
  );

  modport master (
    output M0_REQ, M0_WR, M0_BE, M0_ADDR, M0_WDATA,
    output M1_REQ, M1_WR, M1_BE, M1_ADDR, M1_WDATA,
    input  M0_ACK, M0_RDATA, M0_ERR,
    input  M1_ACK, M1_RDATA, M1_ERR
  );

  modport slave (
    input  S_REQ, S_WR, S_BE, S_ADDR, S_WDATA,
    output S_ACK, S_RDATA
  );

endinterface

// File: rtl/darkbus_rr_pick.sv
// Two-way round-robin chooser: on a tie the master not granted last wins.
module darkbus_rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/darkbus_arbiter.sv
// Two-master round-robin arbiter for the shared RAM/IO slave, with per-access timeout.
//   state     | meaning
//   ST_IDLE   | no owner; grant on any request
//   ST_ACCESS | S_REQ held; wait for S_ACK or timeout
//   ST_RESP   | owner's ACK pulse; no new grant this cycle
module darkbus_arbiter
  import darksoc_pkg::*;
#(
  parameter int unsigned       TIMEOUT  = 16,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic           XCLK,
  input  logic           XRES,
  darkbus_arbiter_if.arb bus,
  output logic [1:0]     GNT
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        gnt_q, gnt_d;
  logic              s_req_q, s_req_d;
  logic              s_wr_q, s_wr_d;
  logic [BE_W-1:0]   s_be_q, s_be_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d;
  logic [1:0]        ack_q, ack_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] rdata_q [2];
  logic [DATA_W-1:0] rdata_d [2];

  logic [1:0]        pick;
  logic              owner;

  darkbus_rr_pick u_pick (
    .req_i  ({bus.M1_REQ, bus.M0_REQ}),
    .last_i (last_q),
    .gnt_o  (pick)
  );

  assign owner = gnt_q[1];

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    s_req_d   = s_req_q;
    s_wr_d    = s_wr_q;
    s_be_d    = s_be_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    ack_d     = 2'b00;
    err_d     = err_q;
    rdata_d   = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (pick != 2'b00) begin
          gnt_d   = pick;
          s_req_d = 1'b1;
          cnt_d   = '0;
          state_d = ST_ACCESS;
          if (pick[1]) begin
            s_wr_d    = bus.M1_WR;
            s_be_d    = bus.M1_BE;
            s_addr_d  = bus.M1_ADDR;
            s_wdata_d = bus.M1_WDATA;
          end else begin
            s_wr_d    = bus.M0_WR;
            s_be_d    = bus.M0_BE;
            s_addr_d  = bus.M0_ADDR;
            s_wdata_d = bus.M0_WDATA;
          end
        end
      end

      ST_ACCESS: begin
        // A slave ack in the last allowed cycle still counts as success.
        if (bus.S_ACK) begin
          rdata_d[owner] = bus.S_RDATA;
          err_d[owner]   = 1'b0;
          ack_d[owner]   = 1'b1;
          s_req_d        = 1'b0;
          state_d        = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d[owner] = ERR_DATA;
          err_d[owner]   = 1'b1;
          ack_d[owner]   = 1'b1;
          s_req_d        = 1'b0;
          state_d        = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      ST_RESP: begin
        last_d  = owner;
        gnt_d   = 2'b00;
        state_d = ST_IDLE;
      end

      default: begin
        gnt_d   = 2'b00;
        s_req_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge XCLK) begin
    if (XRES) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      cnt_q      <= '0;
      gnt_q      <= 2'b00;
      s_req_q    <= 1'b0;
      s_wr_q     <= 1'b0;
      s_be_q     <= '0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      ack_q      <= 2'b00;
      err_q      <= 2'b00;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      s_req_q    <= s_req_d;
      s_wr_q     <= s_wr_d;
      s_be_q     <= s_be_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rdata_q[0] <= rdata_d[0];
      rdata_q[1] <= rdata_d[1];
    end
  end

  assign bus.S_REQ    = s_req_q;
  assign bus.S_WR     = s_wr_q;
  assign bus.S_BE     = s_be_q;
  assign bus.S_ADDR   = s_addr_q;
  assign bus.S_WDATA  = s_wdata_q;
  assign bus.M0_ACK   = ack_q[0];
  assign bus.M1_ACK   = ack_q[1];
  assign bus.M0_ERR   = err_q[0];
  assign bus.M1_ERR   = err_q[1];
  assign bus.M0_RDATA = rdata_q[0];
  assign bus.M1_RDATA = rdata_q[1];
  assign GNT          = gnt_q;

endmodule

// File: doc/darkbus_arbiter.md
Name: darkbus_arbiter

Overview:
Two-master, one-slave arbiter for the darksocv shared data/IO bus. Master 0 is the core data port; master 1 is the debug/loader port. The block grants the single-ported RAM/IO slave round-robin, registers the slave request, and bounds every access with a timeout so a hung slave cannot stall the SoC. It sits between the core and the RAM/IO decoder inside the SoC top, next to the PHS/LED/DEBUG logic.

Parameters:
TIMEOUT, 16, maximum cycles S_REQ stays high waiting for S_ACK (range 2..255).
ERR_DATA, 32'hDEADBEEF, read data returned on a timed-out access.

Ports:
XCLK  in  1  system clock; all logic on the rising edge.
XRES  in  1  reset, synchronous, active-high.
M0_REQ  in  1  master 0 request; held until M0_ACK.
M0_WR  in  1  master 0 write (1) / read (0).
M0_BE  in  4  master 0 byte enables.
M0_ADDR  in  32  master 0 address.
M0_WDATA  in  32  master 0 write data.
M0_ACK  out  1  master 0 one-cycle completion pulse.
M0_RDATA  out  32  master 0 read data; valid while M0_ACK=1.
M0_ERR  out  1  master 0 timeout flag; valid while M0_ACK=1.
M1_REQ, M1_WR, M1_BE, M1_ADDR, M1_WDATA, M1_ACK, M1_RDATA, M1_ERR: same as master 0, for master 1.
S_REQ  out  1  slave request.
S_WR  out  1  slave write.
S_BE  out  4  slave byte enables.
S_ADDR  out  32  slave address.
S_WDATA  out  32  slave write data.
S_ACK  in  1  slave completion; S_RDATA valid in the same cycle.
S_RDATA  in  32  slave read data.
GNT  out  2  one-hot current owner; 00 when idle.

Behaviour:
- Reset (XRES=1 at the edge) forces all of the following on the next edge, aborting any access in flight:
  - state=IDLE, last-grant pointer=1 (so master 0 wins the first tie), timeout counter=0;
  - S_REQ=0, S_WR=0, S_BE=0, S_ADDR=0, S_WDATA=0;
  - M0_ACK=M1_ACK=0, M0_ERR=M1_ERR=0, M0_RDATA=M1_RDATA=0, GNT=00.
- The FSM has three states: IDLE, ACCESS, RESP.
- IDLE:
  - If exactly one REQ is high, that master is granted.
  - If both are high, the master that was not granted last is granted.
  - On grant: latch WR/BE/ADDR/WDATA into the slave registers, set S_REQ=1, set GNT, clear the counter, and go to ACCESS.
  - The slave therefore sees S_REQ one cycle after the master's REQ.
- ACCESS:
  - S_* outputs stay stable.
  - If S_ACK=1: capture S_RDATA into the owner's RDATA, ERR=0, S_REQ=0, go to RESP.
  - Else if counter==TIMEOUT-1: owner's RDATA=ERR_DATA, ERR=1, S_REQ=0, go to RESP.
  - Else: counter+1.
- RESP:
  - The owner's ACK=1 for exactly this cycle.
  - Update the last-grant pointer, set GNT=00, go to IDLE.
  - No grant is made in RESP, so a REQ still high during ACK is not re-served.
- Latency:
  - Zero-wait slave: REQ at cycle t, S_REQ at t+1, ACK at t+2, earliest next grant at t+3.
  - Timeout: ACK at t+TIMEOUT+1 with ERR=1.
- If the master drops REQ during ACCESS, the access still completes and ACK is still pulsed.
- REQ from the non-owner during ACCESS/RESP is held off and is served at the next IDLE.
- The non-owner's ACK, RDATA and ERR do not change.
- Counter width is 8 bits; it never wraps because the timeout fires first.
- S_ACK while in IDLE or RESP is ignored.
- Under continuous contention, grants alternate strictly: M0, M1, M0, …

Decomposition:
- Package darksoc_pkg: state enum (IDLE, ACCESS, RESP), ERR_DATA default, bus width constants (ADDR_W=32, DATA_W=32, BE_W=4).
- One sub-module, darkbus_rr_pick: combinational 2-way round-robin chooser (req[1:0], last → grant one-hot).
- The timeout counter and FSM stay in darkbus_arbiter.

Test Plan:
- Single read, M0_ADDR=0x100, slave acks immediately with S_RDATA=0x12345678 → S_REQ high cycle t+1 only; M0_ACK at t+2 with M0_RDATA=0x12345678, M0_ERR=0; GNT=01 for t+1..t+2.
- Both masters request writes from reset (M0 0x10/0xAA, M1 0x20/0xBB), 1-wait slave → M0 served first, then M1. S_ADDR sequence 0x10, 0x20. Each ACK is a single-cycle pulse; M1_ACK is never asserted during M0's access.
- Continuous REQ on both masters for 6 accesses → GNT sequence 01, 10, 01, 10, 01, 10; no master gets two back-to-back grants.
- Slave never acks, TIMEOUT=16 → S_REQ high for exactly 16 cycles; M1_ACK=1 with M1_RDATA=0xDEADBEEF, M1_ERR=1. A following normal access returns ERR=0.
- XRES asserted mid-ACCESS → next edge: S_REQ=0, GNT=00, no ACK pulse. After release, M0 wins the first tie.
- M0 drops REQ one cycle into ACCESS; slave acks after 3 cycles → M0_ACK still pulses once; no re-grant occurs in RESP.
